uart_rx_controller: RTL and testbench

Sequencing and buffering controller for the UART receiver datapath (`Kennedy_Receiver`). It generates the oversampling `s_tick` and gates the receiver's `rx_enabled`, including a clean shutdown when disabled mid-frame. It captures each completed byte into a small first-word-fall-through FIFO, counts framing errors, and hands bytes to the consumer over a valid/ready interface. The block sits between the receiver and the register/host side of the UART.

---
 rtl/uart_rx_controller_pkg.sv | 22 ++
 rtl/uart_rx_controller_if.sv | 35 +++
 rtl/uart_rx_controller_fifo.sv | 54 +++++
 rtl/uart_rx_controller.sv | 97 +++++++++
 tb/tb_uart_rx_controller.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_controller_pkg.sv
// Shared types and build-time constants for the UART receive controller.
// The tick divisor is derived from the system clock, baud and oversample rates.
package uart_rx_controller_pkg;

    localparam int CLOCK_RATE         = 50_000_000;
    localparam int BAUD_RATE          = 115_200;
    localparam int OVERSAMPLE_RATE    = 16;
    localparam int UART_RX_DIVISOR    = CLOCK_RATE / (BAUD_RATE * OVERSAMPLE_RATE);
    localparam int UART_RX_FIFO_DEPTH = 8;

    typedef enum logic [1:0] {
        DISABLED  = 2'd0,
        LISTEN    = 2'd1,
        RECEIVE   = 2'd2,
        STOPPING  = 2'd3
    } rx_ctrl_state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? 8'hFF : value + 8'd1;
    endfunction

endpackage

// File: rtl/uart_rx_controller_if.sv
// Bundle of receiver-side, consumer-side and status signals of the controller.
// master = the controller, slave = the surrounding receiver/host environment.
interface uart_rx_controller_if
    import uart_rx_controller_pkg::*;
#(
    parameter int FIFO_DEPTH = UART_RX_FIFO_DEPTH
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic             enable;
    logic             clear;
    logic             rx_enabled;
    logic             s_tick;
    logic             rx_busy;
    logic             rx_done;
    logic             rx_err;
    logic [7:0]       rx_data;
    logic             m_valid;
    logic             m_ready;
    logic [7:0]       m_data;
    logic [CNT_W-1:0] fifo_count;
    logic             overflow;
    logic [7:0]       err_count;

    modport master (
        input  enable, clear, rx_busy, rx_done, rx_err, rx_data, m_ready,
        output rx_enabled, s_tick, m_valid, m_data, fifo_count, overflow, err_count
    );

    modport slave (
        output enable, clear, rx_busy, rx_done, rx_err, rx_data, m_ready,
        input  rx_enabled, s_tick, m_valid, m_data, fifo_count, overflow, err_count
    );

endinterface

// File: rtl/uart_rx_controller_fifo.sv
// First-word-fall-through FIFO: the head entry is visible on dout while not empty.
// Storage is not reset; dout is forced to zero when empty so it reads 0 out of reset.
module uart_rx_fifo
    import uart_rx_controller_pkg::*;
#(
    parameter int DEPTH = UART_RX_FIFO_DEPTH,
    parameter int WIDTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A pop frees the slot in the same cycle, so a full FIFO still accepts a push.
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_rx_controller.sv
// UART receive sequencer: gates the receiver, generates the oversampling tick,
// buffers completed bytes in a FWFT FIFO and tracks framing errors / overflow.
module uart_rx_controller
    import uart_rx_controller_pkg::*;
#(
    parameter int FIFO_DEPTH = UART_RX_FIFO_DEPTH,
    parameter int DIVISOR    = UART_RX_DIVISOR
) (
    input logic                 clk,
    input logic                 rstN,
    uart_rx_controller_if.master bus
);
    localparam int DIV_W = $clog2(DIVISOR);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    rx_ctrl_state_t   state;
    rx_ctrl_state_t   state_next;
    logic [DIV_W-1:0] tick_cnt;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic             good_byte;
    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) state <= DISABLED;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            DISABLED: if (bus.enable) state_next = LISTEN;
            LISTEN: begin
                if (!bus.enable)      state_next = DISABLED;
                else if (bus.rx_busy) state_next = RECEIVE;
            end
            RECEIVE: begin
                if (bus.rx_done)      state_next = bus.enable ? LISTEN : DISABLED;
                else if (!bus.enable) state_next = STOPPING;
            end
            STOPPING: begin
                // Finishing the frame wins over a re-enable in the same cycle.
                if (bus.rx_done || !bus.rx_busy) state_next = DISABLED;
                else if (bus.enable)             state_next = RECEIVE;
            end
            default: state_next = DISABLED;
        endcase
    end

    always_comb begin
        bus.rx_enabled = (state != DISABLED);
        bus.s_tick     = bus.rx_enabled && (tick_cnt == DIV_W'(DIVISOR - 1));
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN)                               tick_cnt <= '0;
        else if (!bus.rx_enabled)                tick_cnt <= '0;
        else if (tick_cnt == DIV_W'(DIVISOR - 1)) tick_cnt <= '0;
        else                                     tick_cnt <= tick_cnt + 1'b1;
    end

    assign good_byte = bus.rx_done && !bus.rx_err;
    assign pop       = bus.m_valid && bus.m_ready;

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rstN  (rstN),
        .push  (good_byte),
        .pop   (pop),
        .din   (bus.rx_data),
        .dout  (bus.m_data),
        .count (count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus.fifo_count = count;
    assign bus.m_valid    = !fifo_empty;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            bus.overflow  <= 1'b0;
            bus.err_count <= 8'd0;
        end else if (bus.clear) begin
            bus.overflow  <= 1'b0;
            bus.err_count <= 8'd0;
        end else begin
            if (good_byte && fifo_full && !pop)  bus.overflow  <= 1'b1;
            if (bus.rx_done && bus.rx_err)       bus.err_count <= sat_inc8(bus.err_count);
        end
    end

endmodule

// File: tb/tb_uart_rx_controller.sv
// Directed bench for uart_rx_controller with DIVISOR=4, FIFO_DEPTH=8.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_uart_rx_controller;

    logic clk;
    logic rstN;
    int   pass_cnt;
    int   total_cnt;

    uart_rx_controller_if #(.FIFO_DEPTH(8)) bus ();

    uart_rx_controller #(
        .FIFO_DEPTH (8),
        .DIVISOR    (4)
    ) dut (
        .clk  (clk),
        .rstN (rstN),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rx_enabled"}, 32'(bus.rx_enabled), 32'd0);
        chk({tag, "_s_tick"},     32'(bus.s_tick),     32'd0);
        chk({tag, "_m_valid"},    32'(bus.m_valid),    32'd0);
        chk({tag, "_m_data"},     32'(bus.m_data),     32'd0);
        chk({tag, "_fifo_count"}, 32'(bus.fifo_count), 32'd0);
        chk({tag, "_overflow"},   32'(bus.overflow),   32'd0);
        chk({tag, "_err_count"},  32'(bus.err_count),  32'd0);
    endtask

    initial begin
        logic [11:0] tick_pat;
        int          ticks;
        logic [7:0]  drain_exp [8];

        pass_cnt     = 0;
        total_cnt    = 0;
        rstN         = 1'b0;
        bus.enable   = 1'b0;
        bus.clear    = 1'b0;
        bus.rx_busy  = 1'b0;
        bus.rx_done  = 1'b0;
        bus.rx_err   = 1'b0;
        bus.rx_data  = 8'h00;
        bus.m_ready  = 1'b0;

        // Reset values and idle behaviour
        step(); step();
        chk_reset_outputs("reset");
        rstN = 1'b1;
        ticks = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.s_tick) ticks++;
        end
        chk("no_tick_disabled", 32'(ticks), 32'd0);
        chk("disabled_rx_enabled", 32'(bus.rx_enabled), 32'd0);

        // Enable at cycle 0: rx_enabled at 1, ticks at 4, 8, 12
        bus.enable = 1'b1;
        tick_pat = '0;
        for (int j = 1; j <= 12; j++) begin
            step();
            if (j == 1) chk("enable_latency", 32'(bus.rx_enabled), 32'd1);
            tick_pat[j-1] = bus.s_tick;
        end
        chk("tick_pattern", 32'(tick_pat), 32'h888);

        // Capture two bytes without a consumer, then drain in order
        bus.rx_data = 8'hA5; bus.rx_done = 1'b1;
        step();
        chk("cap1_valid", 32'(bus.m_valid),    32'd1);
        chk("cap1_data",  32'(bus.m_data),     32'hA5);
        chk("cap1_count", 32'(bus.fifo_count), 32'd1);
        bus.rx_data = 8'h5A;
        step();
        bus.rx_done = 1'b0;
        chk("cap2_count", 32'(bus.fifo_count), 32'd2);
        chk("cap2_head",  32'(bus.m_data),     32'hA5);
        bus.m_ready = 1'b1;
        step();
        chk("pop1_data",  32'(bus.m_data),     32'h5A);
        chk("pop1_count", 32'(bus.fifo_count), 32'd1);
        step();
        chk("pop2_valid", 32'(bus.m_valid),    32'd0);
        chk("pop2_count", 32'(bus.fifo_count), 32'd0);
        bus.m_ready = 1'b0;

        // Overflow: nine good bytes into eight entries
        for (int i = 0; i < 9; i++) begin
            bus.rx_data = 8'(i);
            bus.rx_done = 1'b1;
            step();
        end
        bus.rx_done = 1'b0;
        chk("ovf_count", 32'(bus.fifo_count), 32'd8);
        chk("ovf_flag",  32'(bus.overflow),   32'd1);
        chk("ovf_head",  32'(bus.m_data),     32'h00);
        // Push and pop together while full
        bus.rx_data = 8'h77; bus.rx_done = 1'b1; bus.m_ready = 1'b1;
        step();
        bus.rx_done = 1'b0; bus.m_ready = 1'b0;
        chk("full_pp_count", 32'(bus.fifo_count), 32'd8);
        chk("full_pp_flag",  32'(bus.overflow),   32'd1);
        chk("full_pp_head",  32'(bus.m_data),     32'h01);
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
        chk("clear_ovf",       32'(bus.overflow),   32'd0);
        chk("clear_keeps_fifo", 32'(bus.fifo_count), 32'd8);
        bus.rx_data = 8'h88; bus.rx_done = 1'b1; bus.m_ready = 1'b1;
        step();
        bus.rx_done = 1'b0;
        chk("full_pp2_flag",  32'(bus.overflow),   32'd0);
        chk("full_pp2_count", 32'(bus.fifo_count), 32'd8);
        drain_exp = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h77, 8'h88};
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain_%0d", i), 32'(bus.m_data), 32'(drain_exp[i]));
            step();
        end
        bus.m_ready = 1'b0;
        chk("drain_empty", 32'(bus.m_valid), 32'd0);

        // Framing errors
        bus.rx_err = 1'b1; bus.rx_data = 8'hFF; bus.rx_done = 1'b1;
        for (int i = 0; i < 3; i++) step();
        bus.rx_done = 1'b0;
        chk("err3_count", 32'(bus.err_count),  32'd3);
        chk("err3_fifo",  32'(bus.fifo_count), 32'd0);
        chk("err3_valid", 32'(bus.m_valid),    32'd0);
        bus.rx_done = 1'b1;
        for (int i = 0; i < 300; i++) step();
        chk("err_sat", 32'(bus.err_count), 32'd255);
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0; bus.rx_done = 1'b0; bus.rx_err = 1'b0;
        chk("err_clear_prio", 32'(bus.err_count), 32'd0);

        // Disable mid-frame
        bus.rx_busy = 1'b1;
        step();
        bus.enable = 1'b0;
        step();
        chk("stop_rx_enabled", 32'(bus.rx_enabled), 32'd1);
        ticks = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.s_tick) ticks++;
            step();
        end
        chk("stop_ticks", 32'(ticks), 32'd1);
        chk("stop_rx_enabled2", 32'(bus.rx_enabled), 32'd1);
        bus.rx_data = 8'h34; bus.rx_done = 1'b1;
        step();
        bus.rx_done = 1'b0; bus.rx_busy = 1'b0;
        chk("stop_exit",  32'(bus.rx_enabled), 32'd0);
        chk("stop_valid", 32'(bus.m_valid),    32'd1);
        chk("stop_data",  32'(bus.m_data),     32'h34);
        bus.m_ready = 1'b1;
        step();
        bus.m_ready = 1'b0;
        chk("stop_popped", 32'(bus.fifo_count), 32'd0);

        // Reset mid-operation
        bus.enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.rx_data = 8'(8'h10 + i); bus.rx_done = 1'b1;
            step();
        end
        bus.rx_err = 1'b1;
        for (int i = 0; i < 5; i++) step();
        bus.rx_done = 1'b0; bus.rx_err = 1'b0;
        chk("pre_rst_count", 32'(bus.fifo_count), 32'd3);
        chk("pre_rst_err",   32'(bus.err_count),  32'd5);
        chk("pre_rst_en",    32'(bus.rx_enabled), 32'd1);
        #2;
        rstN = 1'b0;
        #1;
        chk_reset_outputs("async_rst");
        bus.enable = 1'b0;
        step();
        rstN = 1'b1;
        step();
        chk("post_rst_valid", 32'(bus.m_valid),    32'd0);
        chk("post_rst_count", 32'(bus.fifo_count), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
